// File: rtl/bulk_fifo_endp.sv
// bulk_fifo_endp: USB FS bulk IN/OUT endpoint pair with packet-level commit/rollback FIFOs.
// Define BULK_ZLP_EN to send a zero-length packet after an exactly max-size final IN packet.
module bulk_fifo_endp #(
   parameter int IN_BULK_MAXPACKETSIZE  = 8,
   parameter int OUT_BULK_MAXPACKETSIZE = 8,
   parameter int IN_FIFO_DEPTH          = 16,
   parameter int OUT_FIFO_DEPTH         = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [7:0]                        app_in_data_i,
   input  logic                              app_in_valid_i,
   output logic                              app_in_ready_o,
   output logic [7:0]                        app_out_data_o,
   output logic                              app_out_valid_o,
   input  logic                              app_out_ready_i,
   output logic [$clog2(IN_FIFO_DEPTH):0]    app_in_level_o,
   output logic [$clog2(OUT_FIFO_DEPTH):0]   app_out_level_o,
   output logic [7:0]                        in_data_o,
   output logic                              in_valid_o,
   input  logic                              in_req_i,
   input  logic                              in_ready_i,
   output logic                              in_zlp_o,
   output logic                              out_nak_o,
   input  logic [7:0]                        out_data_i,
   input  logic                              out_valid_i,
   input  logic                              out_err_i,
   input  logic                              out_ready_i
);
   localparam int IW = $clog2(IN_FIFO_DEPTH);
   localparam int OW = $clog2(OUT_FIFO_DEPTH);
   typedef enum logic {IN_IDLE, IN_ACTIVE} in_state_t;
   typedef enum logic [1:0] {OUT_IDLE, OUT_DATA, OUT_DROP} out_state_t;

   logic [7:0]  in_mem [IN_FIFO_DEPTH];
   logic [IW:0] in_wr, in_rd_commit, in_rd_spec, in_rd_commit_nxt;
   logic [6:0]  pkt_cnt;
   logic        in_req_q, in_push, in_pop, in_ack;
   in_state_t   in_state;

   assign app_in_level_o   = in_wr - in_rd_commit;
   assign app_in_ready_o   = app_in_level_o != (IW+1)'(IN_FIFO_DEPTH);
   assign in_push          = app_in_valid_i & app_in_ready_o;
   assign in_valid_o       = (in_state == IN_ACTIVE) & in_req_i & (in_rd_spec != in_wr) & (pkt_cnt < 7'(IN_BULK_MAXPACKETSIZE));
   assign in_pop           = in_valid_o & in_ready_i;
   assign in_data_o        = in_valid_o ? in_mem[in_rd_spec[IW-1:0]] : 8'h00;
   assign in_ack           = (in_state == IN_ACTIVE) & out_ready_i & !out_valid_i & !out_err_i;
   assign in_rd_commit_nxt = in_ack ? in_rd_spec : in_rd_commit;

   always_ff @(posedge clk_i)
      if (in_push) in_mem[in_wr[IW-1:0]] <= app_in_data_i;

   // A new IN token rewinds to the committed pointer so an un-ACKed packet is resent
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         in_state     <= IN_IDLE;
         in_req_q     <= 1'b0;
         in_wr        <= '0;
         in_rd_commit <= '0;
         in_rd_spec   <= '0;
         pkt_cnt      <= '0;
      end else begin
         in_req_q     <= in_req_i;
         in_rd_commit <= in_rd_commit_nxt;
         if (in_push) in_wr <= in_wr + 1'b1;
         if (in_req_i & !in_req_q) begin
            in_state   <= IN_ACTIVE;
            in_rd_spec <= in_rd_commit_nxt;
            pkt_cnt    <= '0;
         end else begin
            if (in_pop) begin
               in_rd_spec <= in_rd_spec + 1'b1;
               pkt_cnt    <= pkt_cnt + 7'd1;
            end
            if (in_ack | !in_req_i) in_state <= IN_IDLE;
         end
      end

`ifdef BULK_ZLP_EN
   logic last_full;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) last_full <= 1'b0;
      else if (in_ack) last_full <= pkt_cnt == 7'(IN_BULK_MAXPACKETSIZE);
   assign in_zlp_o = (in_state == IN_ACTIVE) & in_req_i & last_full & (in_rd_spec == in_wr);
`else
   assign in_zlp_o = 1'b0;
`endif

   logic [7:0]    out_mem [OUT_FIFO_DEPTH];
   logic [OW:0]   out_rd, out_wr_commit, out_wr_spec;
   logic [OW+1:0] out_free;
   logic [6:0]    byte_cnt;
   logic          out_byte, out_eop, out_abort, out_admit, out_wr_en, app_pop;
   out_state_t    out_state;

   assign app_out_level_o = out_wr_commit - out_rd;
   assign app_out_valid_o = app_out_level_o != '0;
   assign app_out_data_o  = app_out_valid_o ? out_mem[out_rd[OW-1:0]] : 8'h00;
   assign app_pop         = app_out_valid_o & app_out_ready_i;
   assign out_free        = (OW+2)'(OUT_FIFO_DEPTH) - {1'b0, app_out_level_o};
   assign out_admit       = out_free >= (OW+2)'(OUT_BULK_MAXPACKETSIZE);
   assign out_abort       = out_ready_i & out_err_i;
   assign out_eop         = out_ready_i & !out_valid_i & !out_err_i;
   assign out_byte        = out_ready_i & out_valid_i & !out_err_i;
   assign out_wr_en       = out_byte & (((out_state == OUT_IDLE) & out_admit) |
                                        ((out_state == OUT_DATA) & (byte_cnt != 7'(OUT_BULK_MAXPACKETSIZE))));

   always_ff @(posedge clk_i)
      if (out_wr_en) out_mem[out_wr_spec[OW-1:0]] <= out_data_i;

   // Admission needs room for a whole max-size packet, so a babbling packet can never overflow
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         out_state     <= OUT_IDLE;
         out_rd        <= '0;
         out_wr_commit <= '0;
         out_wr_spec   <= '0;
         byte_cnt      <= '0;
         out_nak_o     <= 1'b0;
      end else begin
         if (app_pop) out_rd <= out_rd + 1'b1;
         if (out_wr_en) begin
            out_wr_spec <= out_wr_spec + 1'b1;
            byte_cnt    <= (out_state == OUT_IDLE) ? 7'd1 : byte_cnt + 7'd1;
         end
         if (out_abort) begin
            out_wr_spec <= out_wr_commit;
            out_nak_o   <= 1'b0;
            out_state   <= OUT_IDLE;
         end else if (out_eop) begin
            if (out_state == OUT_DATA) out_wr_commit <= out_wr_spec;
            if (out_state == OUT_DROP) out_wr_spec <= out_wr_commit;
            out_state <= OUT_IDLE;
         end else if (out_byte) begin
            if (out_state == OUT_IDLE) out_nak_o <= !out_admit;
            out_state <= (out_state == OUT_IDLE) ? (out_admit ? OUT_DATA : OUT_DROP) :
                         (byte_cnt == 7'(OUT_BULK_MAXPACKETSIZE)) ? OUT_DROP : out_state;
         end
      end
endmodule
